sync_fifo: RTL and testbench

//   Single-clock FIFO with integrated storage, fill count, programmable almost-full/empty

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_if.sv | 37 +++
 rtl/sync_fifo_ram.sv | 23 ++
 rtl/sync_fifo.sv | 129 ++++++++++++
 tb/tb_sync_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the byte FIFO between the UART datapaths and the host bus.
package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle of sync_fifo; the master drives requests, the FIFO is the slave.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Depth     = 16
);
  localparam int CntWidth = $clog2(Depth) + 1;

  logic                 flush;
  logic                 clr_err;
  logic                 wr_en;
  logic [DataWidth-1:0] wr_data;
  logic                 rd_en;
  logic [DataWidth-1:0] rd_data;
  logic                 rd_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CntWidth-1:0]  count;
  logic                 overflow;
  logic                 underflow;
  fifo_status_t         status;

  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, status
  );

  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, status
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read address (LUTRAM-friendly).
module sync_fifo_ram #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost thresholds, flush, sticky error flags and
// selectable standard / first-word-fall-through read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DataWidth      = 8,
  parameter int Depth          = 16,
  parameter int AlmostFullThr  = 12,
  parameter int AlmostEmptyThr = 2,
  parameter int Fwft           = 0
) (
  input logic        i_clk,
  input logic        i_rst_n,
  sync_fifo_if.slave bus
);

  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] AfThr = CntWidth'(AlmostFullThr);
  localparam logic [CntWidth-1:0] AeThr = CntWidth'(AlmostEmptyThr);

  if (!is_pow2(Depth) || Depth < 2) begin : g_chk_depth
    $error("sync_fifo: Depth must be a power of two and at least 2");
  end
  if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_chk_af
    $error("sync_fifo: AlmostFullThr must be in 1..Depth");
  end
  if (AlmostEmptyThr < 0 || AlmostEmptyThr > Depth - 1) begin : g_chk_ae
    $error("sync_fifo: AlmostEmptyThr must be in 0..Depth-1");
  end
  if (Fwft != 0 && Fwft != 1) begin : g_chk_fwft
    $error("sync_fifo: Fwft must be 0 or 1");
  end

  logic [PtrWidth:0]    wr_ptr;
  logic [PtrWidth:0]    rd_ptr;
  logic [CntWidth-1:0]  count;
  logic                 full;
  logic                 empty;
  logic                 wr_push;
  logic                 rd_pop;
  logic                 ovf_set;
  logic                 udf_set;
  logic                 overflow_q;
  logic                 underflow_q;
  logic [DataWidth-1:0] ram_rdata;

  // MSB of each pointer is the lap bit: equal low bits with differing laps means full
  assign full  = (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]) &&
                 (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign wr_push = bus.wr_en && !full  && !bus.flush;
  assign rd_pop  = bus.rd_en && !empty && !bus.flush;
  assign ovf_set = bus.wr_en && full  && !bus.flush;
  assign udf_set = bus.rd_en && empty && !bus.flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_push) wr_ptr <= wr_ptr + 1'b1;
        if (rd_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // a new error in the same cycle as a clear keeps the flag set
      overflow_q  <= ovf_set || (overflow_q  && !bus.clr_err);
      underflow_q <= udf_set || (underflow_q && !bus.clr_err);
    end
  end

  sync_fifo_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_ram (
    .i_clk (i_clk),
    .we    (wr_push && i_rst_n),
    .waddr (wr_ptr[PtrWidth-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[PtrWidth-1:0]),
    .rdata (ram_rdata)
  );

  if (Fwft == 0) begin : g_std
    logic [DataWidth-1:0] rd_data_q;
    logic                 rd_valid_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_pop;
        if (rd_pop) rd_data_q <= ram_rdata;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end else begin : g_fwft
    assign bus.rd_data  = ram_rdata;
    assign bus.rd_valid = !empty;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AfThr);
  assign bus.almost_empty = (count <= AeThr);
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  assign bus.status = '{
    full:         full,
    empty:        empty,
    almost_full:  (count >= AfThr),
    almost_empty: (count <= AeThr),
    overflow:     overflow_q,
    underflow:    underflow_q
  };

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: standard and FWFT instances share stimulus and a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic          flush   = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DataWidth(DW), .Depth(DEPTH)) bus_s ();
  sync_fifo_if #(.DataWidth(DW), .Depth(DEPTH)) bus_f ();

  assign bus_s.wr_en   = wr_en;
  assign bus_s.wr_data = wr_data;
  assign bus_s.rd_en   = rd_en;
  assign bus_s.flush   = flush;
  assign bus_s.clr_err = clr_err;
  assign bus_f.wr_en   = wr_en;
  assign bus_f.wr_data = wr_data;
  assign bus_f.rd_en   = rd_en;
  assign bus_f.flush   = flush;
  assign bus_f.clr_err = clr_err;

  sync_fifo #(
    .DataWidth(DW), .Depth(DEPTH), .AlmostFullThr(AF), .AlmostEmptyThr(AE), .Fwft(0)
  ) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s)
  );

  sync_fifo #(
    .DataWidth(DW), .Depth(DEPTH), .AlmostFullThr(AF), .AlmostEmptyThr(AE), .Fwft(1)
  ) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_f)
  );

  // reference model: contents as a queue, plus sticky flags and the last popped word
  logic [DW-1:0] m_q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic          m_rdv = 1'b0;
  logic [DW-1:0] m_rdd = '0;

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic c, input logic rs);
    bit was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c; rst_n = rs;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (!rs) begin
      m_q.delete(); m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = '0;
    end else if (f) begin
      m_q.delete(); m_rdv = 0;
      m_ovf = m_ovf && !c;
      m_udf = m_udf && !c;
    end else begin
      m_ovf = (w && was_full)  || (m_ovf && !c);
      m_udf = (r && was_empty) || (m_udf && !c);
      m_rdv = r && !was_empty;
      if (m_rdv) m_rdd = m_q.pop_front();
      if (w && !was_full) m_q.push_back(d);
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; rst_n = 1;
  endtask

  task automatic wr(input logic [DW-1:0] d); step(1, d, 0, 0, 0, 1); endtask
  task automatic rd();                       step(0, '0, 1, 0, 0, 1); endtask
  task automatic idle();                     step(0, '0, 0, 0, 0, 1); endtask

  task automatic test_reset();
    step(0, '0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus_s.empty, bus_s.full, bus_s.almost_empty, bus_s.almost_full} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_flags: got e/f/ae/af=%b%b%b%b want 1010",
               bus_s.empty, bus_s.full, bus_s.almost_empty, bus_s.almost_full);
    end
    n_cmp++;
    if (bus_s.count !== 5'd0 || bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_cnt_err: got cnt=%0d ovf=%b udf=%b want 0/0/0",
               bus_s.count, bus_s.overflow, bus_s.underflow);
    end
    n_cmp++;
    if (bus_s.rd_valid !== 1'b0 || bus_s.rd_data !== 8'h00 || bus_f.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rd: got vld=%b data=%h fwft_vld=%b want 0/00/0",
               bus_s.rd_valid, bus_s.rd_data, bus_f.rd_valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      wr(8'(i));
      n_cmp++;
      if (bus_s.count !== 5'(i)) begin
        n_err++; $display("FAIL fill_count: got %0d want %0d", bus_s.count, i);
      end
    end
    n_cmp++;
    if (bus_s.full !== 1'b1) begin
      n_err++; $display("FAIL fill_full: got %b want 1", bus_s.full);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      rd();
      n_cmp++;
      if (bus_s.rd_valid !== 1'b1 || bus_s.rd_data !== 8'(i)) begin
        n_err++;
        $display("FAIL drain_data: got vld=%b data=%h want 1/%h", bus_s.rd_valid, bus_s.rd_data, 8'(i));
      end
      n_cmp++;
      if (bus_s.count !== 5'(DEPTH - i)) begin
        n_err++; $display("FAIL drain_count: got %0d want %0d", bus_s.count, DEPTH - i);
      end
    end
    n_cmp++;
    if (bus_s.empty !== 1'b1) begin
      n_err++; $display("FAIL drain_empty: got %b want 1", bus_s.empty);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d = 8'h40;
    for (int lap = 0; lap < 3; lap++) begin
      for (int j = 0; j < 10; j++) begin
        wr(d); d++;
        n_cmp++;
        if (bus_s.full !== 1'b0) begin
          n_err++; $display("FAIL wrap_full: lap %0d got %b want 0", lap, bus_s.full);
        end
      end
      for (int j = 0; j < 10; j++) begin
        rd();
        n_cmp++;
        if (bus_s.rd_valid !== 1'b1 || bus_s.rd_data !== m_rdd) begin
          n_err++;
          $display("FAIL wrap_data: lap %0d got vld=%b data=%h want 1/%h",
                   lap, bus_s.rd_valid, bus_s.rd_data, m_rdd);
        end
      end
      n_cmp++;
      if (bus_s.count !== 5'd0) begin
        n_err++; $display("FAIL wrap_count: lap %0d got %0d want 0", lap, bus_s.count);
      end
    end
  endtask

  task automatic test_thresholds();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i > 0) wr(8'(i + 8'h80));
      n_cmp++;
      if (bus_s.almost_empty !== (i <= AE) || bus_s.almost_full !== (i >= AF)) begin
        n_err++;
        $display("FAIL threshold: count %0d got ae=%b af=%b want ae=%b af=%b",
                 i, bus_s.almost_empty, bus_s.almost_full, (i <= AE), (i >= AF));
      end
    end
    for (int i = 0; i < DEPTH; i++) rd();
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < DEPTH; i++) wr(8'(i + 8'h20));
    step(1, 8'h77, 1, 0, 0, 1);
    n_cmp++;
    if (bus_s.count !== 5'd15 || bus_s.overflow !== 1'b1 || bus_s.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL wr_rd_full: got cnt=%0d ovf=%b udf=%b want 15/1/0",
               bus_s.count, bus_s.overflow, bus_s.underflow);
    end
    n_cmp++;
    if (bus_s.rd_valid !== 1'b1 || bus_s.rd_data !== 8'h20) begin
      n_err++; $display("FAIL wr_rd_full_data: got %b/%h want 1/20", bus_s.rd_valid, bus_s.rd_data);
    end
    for (int i = 0; i < DEPTH - 1; i++) rd();
    step(1, 8'h33, 1, 0, 0, 1);
    n_cmp++;
    if (bus_s.count !== 5'd1 || bus_s.underflow !== 1'b1 || bus_s.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_rd_empty: got cnt=%0d udf=%b vld=%b want 1/1/0",
               bus_s.count, bus_s.underflow, bus_s.rd_valid);
    end
    step(0, '0, 0, 0, 1, 1);
    n_cmp++;
    if (bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0) begin
      n_err++; $display("FAIL clr_err: got ovf=%b udf=%b want 0/0", bus_s.overflow, bus_s.underflow);
    end
    rd();
    n_cmp++;
    if (bus_s.rd_data !== 8'h33) begin
      n_err++; $display("FAIL empty_write_data: got %h want 33", bus_s.rd_data);
    end
    step(0, '0, 1, 0, 1, 1);
    n_cmp++;
    if (bus_s.underflow !== 1'b1) begin
      n_err++; $display("FAIL clr_vs_set: got udf=%b want 1", bus_s.underflow);
    end
    step(0, '0, 0, 0, 1, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) wr(8'(i + 8'h50));
    step(1, 8'h55, 0, 1, 0, 1);
    n_cmp++;
    if (bus_s.count !== 5'd0 || bus_s.empty !== 1'b1 ||
        bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0) begin
      n_err++;
      $display("FAIL flush_wr: got cnt=%0d empty=%b ovf=%b udf=%b want 0/1/0/0",
               bus_s.count, bus_s.empty, bus_s.overflow, bus_s.underflow);
    end
    for (int i = 0; i < 3; i++) wr(8'(i + 8'h60));
    step(0, '0, 1, 1, 0, 1);
    n_cmp++;
    if (bus_s.rd_valid !== 1'b0 || bus_f.rd_valid !== 1'b0 || bus_s.count !== 5'd0) begin
      n_err++;
      $display("FAIL flush_rd: got vld=%b fwft_vld=%b cnt=%0d want 0/0/0",
               bus_s.rd_valid, bus_f.rd_valid, bus_s.count);
    end
  endtask

  task automatic test_reset_mid();
    rd();
    for (int i = 0; i < 5; i++) wr(8'(i + 8'h90));
    rd();
    step(1, 8'hEE, 1, 0, 0, 0);
    n_cmp++;
    if (bus_s.count !== 5'd0 || bus_s.empty !== 1'b1 || bus_s.full !== 1'b0 ||
        bus_s.almost_empty !== 1'b1 || bus_s.almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_flags: got cnt=%0d e=%b f=%b ae=%b af=%b want 0/1/0/1/0",
               bus_s.count, bus_s.empty, bus_s.full, bus_s.almost_empty, bus_s.almost_full);
    end
    n_cmp++;
    if (bus_s.overflow !== 1'b0 || bus_s.underflow !== 1'b0 ||
        bus_s.rd_valid !== 1'b0 || bus_s.rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_rd: got ovf=%b udf=%b vld=%b data=%h want 0/0/0/00",
               bus_s.overflow, bus_s.underflow, bus_s.rd_valid, bus_s.rd_data);
    end
  endtask

  task automatic test_fwft();
    wr(8'hA5);
    n_cmp++;
    if (bus_f.rd_valid !== 1'b1 || bus_f.rd_data !== 8'hA5) begin
      n_err++; $display("FAIL fwft_first: got %b/%h want 1/a5", bus_f.rd_valid, bus_f.rd_data);
    end
    wr(8'h5A);
    n_cmp++;
    if (bus_f.rd_data !== 8'hA5) begin
      n_err++; $display("FAIL fwft_head_hold: got %h want a5", bus_f.rd_data);
    end
    rd();
    n_cmp++;
    if (bus_f.rd_valid !== 1'b1 || bus_f.rd_data !== 8'h5A) begin
      n_err++; $display("FAIL fwft_next: got %b/%h want 1/5a", bus_f.rd_valid, bus_f.rd_data);
    end
    rd();
    n_cmp++;
    if (bus_f.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL fwft_pop: got vld=%b want 0", bus_f.rd_valid);
    end
  endtask

  task automatic test_random();
    bit fill_phase = 1;
    logic [5:0] exp_flags;
    logic [5:0] got_flags;
    for (int n = 0; n < 800; n++) begin
      if (n % 37 == 0) fill_phase = !fill_phase;
      step($urandom_range(0, 99) < (fill_phase ? 75 : 30), 8'($urandom),
           $urandom_range(0, 99) < (fill_phase ? 30 : 75),
           $urandom_range(0, 59) == 0, $urandom_range(0, 15) == 0, 1'b1);
      exp_flags = {m_q.size() == DEPTH, m_q.size() == 0, m_q.size() >= AF,
                   m_q.size() <= AE, m_ovf, m_udf};
      got_flags = {bus_s.full, bus_s.empty, bus_s.almost_full,
                   bus_s.almost_empty, bus_s.overflow, bus_s.underflow};
      n_cmp++;
      if (got_flags !== exp_flags || bus_s.count !== 5'(m_q.size())) begin
        n_err++;
        $display("FAIL rand_status: cyc %0d got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 n, got_flags, bus_s.count, exp_flags, m_q.size());
      end
      n_cmp++;
      if (bus_f.status !== fifo_status_t'(exp_flags)) begin
        n_err++;
        $display("FAIL rand_status_bus: cyc %0d got %b want %b", n, bus_f.status, exp_flags);
      end
      n_cmp++;
      if (bus_s.rd_valid !== m_rdv || (m_rdv && bus_s.rd_data !== m_rdd)) begin
        n_err++;
        $display("FAIL rand_rd: cyc %0d got vld=%b data=%h want vld=%b data=%h",
                 n, bus_s.rd_valid, bus_s.rd_data, m_rdv, m_rdd);
      end
      n_cmp++;
      if (bus_f.rd_valid !== (m_q.size() != 0) ||
          (m_q.size() != 0 && bus_f.rd_data !== m_q[0])) begin
        n_err++;
        $display("FAIL rand_fwft: cyc %0d got vld=%b data=%h want vld=%b",
                 n, bus_f.rd_valid, bus_f.rd_data, (m_q.size() != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_thresholds();
    test_boundaries();
    test_flush();
    test_reset_mid();
    test_fwft();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
